hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage load-use stall logic.
- Keeps a per-register countdown scoreboard of results that cannot yet be forwarded, which allows configurable load latency and multiple long-latency opcodes.
- Stalls the decode instruction while any source it reads is pending, and clears on pipeline flush.
- Adds per-register busy visibility and a saturating stall-cycle performance counter; sits between decode and register-read.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_scoreboard_sb_entry.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Purpose : shared opcode constants and latency-class decode for the hazard scoreboard.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package hazard_pkg;

  // Opcode field width the constants below are written for.
  localparam int OPC_W = 4;

  // Opcodes whose results come out of the memory stage and so cannot be
  // forwarded back to the instruction directly behind them.
  localparam logic [OPC_W-1:0] OP_LW = 4'b0100;
  localparam logic [OPC_W-1:0] OP_LM = 4'b0110;

  // Bubbles needed between a load and its first consumer on the current pipe.
  localparam int LOAD_LAT_DEF = 1;

  typedef enum logic {
    LAT_FWD  = 1'b0,  // result forwarded, no scoreboard entry needed
    LAT_LOAD = 1'b1   // result late, scoreboard holds it for LOAD_LAT cycles
  } lat_class_e;

  function automatic lat_class_e lat_of(input logic [OPC_W-1:0] op);
    lat_class_e cls;
    cls = LAT_FWD;
    if ((op == OP_LW) || (op == OP_LM)) begin
      cls = LAT_LOAD;
    end
    return cls;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// Purpose : countdown for one architectural register whose result is not yet forwardable.
// Latency : count visible the cycle after set; busy is a combinational view of the count.
// Backpr. : none; clr overrides set, set overrides the per-cycle decrement.
//
// Ports: clk/rst_n clock and async active-low reset; set/set_val load the counter;
//        clr zeroes it (pipeline flush); busy is high while the counter is non-zero.
module sb_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [CNT_W-1:0] set_val,
  input  logic             clr,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (set) begin
      cnt_d = set_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose : decode-stage stall logic; tracks per-register pending long-latency results.
// Latency : should_stall is combinational from current counters; busy_vec/stall_count registered.
// Backpr. : should_stall holds PC/IF/ID and bubbles register-read; flush clears everything.
//
// Ports: dec_* describe the instruction sitting in decode; flush squashes decode and younger;
//        should_stall = stall decode this cycle; busy_vec = per-register pending view;
//        stall_count = saturating count of stalled cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int OP_W     = 4,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  input  logic [OP_W-1:0]     dec_op,
  input  logic [REG_W-1:0]    dec_src1,
  input  logic [REG_W-1:0]    dec_src2,
  input  logic                dec_src1_used,
  input  logic                dec_src2_used,
  input  logic [REG_W-1:0]    dec_dest,
  input  logic                dec_dest_wr,
  input  logic                flush,
  output logic                should_stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [PERF_W-1:0]   stall_count
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_vec;
  logic                dep1;
  logic                dep2;
  logic                stall;
  logic                accept;
  logic                is_load;
  logic [PERF_W-1:0]   stall_count_q;
  logic [PERF_W-1:0]   stall_count_d;

  assign is_load = (lat_of(dec_op) == LAT_LOAD) && (LOAD_LAT != 0);

  // Sources are compared against every tracked index instead of indexing
  // busy directly, so an index beyond NUM_REGS simply never matches.
  always_comb begin
    dep1 = 1'b0;
    dep2 = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (dec_src1 == REG_W'(r)) begin
        dep1 = dec_src1_used & busy[r];
      end
      if (dec_src2 == REG_W'(r)) begin
        dep2 = dec_src2_used & busy[r];
      end
    end
  end

  // Flush wins over stall: a squashed instruction has nothing to wait for.
  assign stall  = dec_valid & ~flush & (dep1 | dep2);
  assign accept = dec_valid & ~stall & ~flush;

  // Dependence uses the pre-edge counters, so an instruction that reads and
  // writes the same register does not stall on its own destination.
  always_comb begin
    set_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      set_vec[r] = accept & dec_dest_wr & is_load & (dec_dest == REG_W'(r));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (set_vec[g]),
      .set_val (CNT_W'(LOAD_LAT)),
      .clr     (flush),
      .busy    (busy[g])
    );
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign should_stall = stall;
  assign busy_vec     = busy;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       dec_valid;
  logic [3:0] dec_op;
  logic [2:0] dec_src1;
  logic [2:0] dec_src2;
  logic       dec_src1_used;
  logic       dec_src2_used;
  logic [2:0] dec_dest;
  logic       dec_dest_wr;
  logic       flush;

  logic        stall_a, stall_b;
  logic [7:0]  busy_a, busy_b;
  logic [15:0] sc_a;
  logic [3:0]  sc_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  // Two builds share one stimulus stream: default (LOAD_LAT=1, PERF_W=16)
  // and a deeper memory pipe with a small perf counter (LOAD_LAT=3, PERF_W=4).
  hazard_scoreboard dut_a (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_op(dec_op),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_dest(dec_dest), .dec_dest_wr(dec_dest_wr), .flush(flush),
    .should_stall(stall_a), .busy_vec(busy_a), .stall_count(sc_a)
  );

  hazard_scoreboard #(.LOAD_LAT(3), .PERF_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_op(dec_op),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_dest(dec_dest), .dec_dest_wr(dec_dest_wr), .flush(flush),
    .should_stall(stall_b), .busy_vec(busy_b), .stall_count(sc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each register remembers the absolute cycle at which its value
  // becomes forwardable; a source is pending while now < that cycle.
  int cyc_m;
  int ready_m [2][8];
  int sc_m    [2];
  int lat_m   [2] = '{1, 3};
  int scmax_m [2] = '{65535, 15};

  function automatic bit m_is_load(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b0110);
  endfunction

  function automatic bit m_stall(input int k);
    bit p1, p2;
    p1 = dec_src1_used && (cyc_m < ready_m[k][dec_src1]);
    p2 = dec_src2_used && (cyc_m < ready_m[k][dec_src2]);
    return dec_valid && !flush && (p1 || p2);
  endfunction

  function automatic logic [7:0] m_busy(input int k);
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = (cyc_m < ready_m[k][r]);
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_m = 0;
      for (int k = 0; k < 2; k++) begin
        sc_m[k] = 0;
        for (int r = 0; r < 8; r++) ready_m[k][r] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit st;
        st = m_stall(k);
        if (flush) begin
          for (int r = 0; r < 8; r++) ready_m[k][r] = 0;
        end else if (dec_valid && !st && dec_dest_wr && m_is_load(dec_op)) begin
          ready_m[k][dec_dest] = cyc_m + 1 + lat_m[k];
        end
        if (st && sc_m[k] < scmax_m[k]) sc_m[k] = sc_m[k] + 1;
      end
      cyc_m = cyc_m + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model stall_a", 32'(stall_a), 32'(m_stall(0)));
      check("model busy_a",  32'(busy_a),  32'(m_busy(0)));
      check("model count_a", 32'(sc_a),    32'(sc_m[0]));
      check("model stall_b", 32'(stall_b), 32'(m_stall(1)));
      check("model busy_b",  32'(busy_b),  32'(m_busy(1)));
      check("model count_b", 32'(sc_b),    32'(sc_m[1]));
    end
  end

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [2:0] s1, input logic s1u,
                       input logic [2:0] s2, input logic s2u,
                       input logic [2:0] d, input logic dw, input logic fl);
    dec_valid = v; dec_op = op;
    dec_src1 = s1; dec_src1_used = s1u;
    dec_src2 = s2; dec_src2_used = s2u;
    dec_dest = d;  dec_dest_wr = dw; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [2:0] d);
    drive(1'b1, 4'b0100, 3'd0, 1'b0, 3'd0, 1'b0, d, 1'b1, 1'b0);
  endtask

  // ADD reading src1, writing R4.
  task automatic use1(input logic [2:0] s, input logic fl);
    drive(1'b1, 4'b0000, s, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, fl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    cmp_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset then idle
    @(negedge clk);
    check("reset stall_a", 32'(stall_a), 32'd0);
    check("reset busy_a",  32'(busy_a),  32'h00);
    check("reset count_a", 32'(sc_a),    32'd0);
    check("reset busy_b",  32'(busy_b),  32'h00);
    tick();

    // Load-use: LW R3 then ADD reading R3
    lw(3'd3); tick();
    use1(3'd3, 1'b0);
    @(negedge clk);
    check("lu stall_a c1", 32'(stall_a), 32'd1);
    check("lu busy_a c1",  32'(busy_a),  32'h08);
    check("lu busy_b c1",  32'(busy_b),  32'h08);
    tick();
    @(negedge clk);
    check("lu stall_a c2", 32'(stall_a), 32'd0);
    check("lu count_a c2", 32'(sc_a),    32'd1);
    check("lu stall_b c2", 32'(stall_b), 32'd1);
    tick(); tick();
    @(negedge clk);
    check("lu stall_b c4", 32'(stall_b), 32'd0);
    check("lu count_b c4", 32'(sc_b),    32'd3);
    idle(); tick();

    // LW R5 then SW reading R5 on src2
    lw(3'd5); tick();
    drive(1'b1, 4'b0101, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("sw stall_b", 32'(stall_b), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    check("sw stall_b done", 32'(stall_b), 32'd0);
    check("sw count_b",      32'(sc_b),    32'd6);
    check("sw count_a",      32'(sc_a),    32'd2);
    lw(3'd5); tick();
    drive(1'b1, 4'b0101, 3'd0, 1'b0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("src2 unused stall_b", 32'(stall_b), 32'd0);
    check("src2 unused busy_b",  32'(busy_b),  32'h20);
    idle(); repeat (4) tick();

    // Non-load producer
    drive(1'b1, 4'b0000, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0); tick();
    use1(3'd2, 1'b0);
    @(negedge clk);
    check("alu stall_a", 32'(stall_a), 32'd0);
    check("alu busy_a",  32'(busy_a),  32'h00);
    check("alu busy_b",  32'(busy_b),  32'h00);
    tick(); idle(); tick();

    // Flush in the stall cycle
    lw(3'd1); tick();
    use1(3'd1, 1'b1);
    @(negedge clk);
    check("flush stall_a", 32'(stall_a), 32'd0);
    check("flush stall_b", 32'(stall_b), 32'd0);
    tick(); idle();
    @(negedge clk);
    check("flush busy_a", 32'(busy_a), 32'h00);
    check("flush busy_b", 32'(busy_b), 32'h00);
    check("flush count_a", 32'(sc_a),  32'd2);
    tick();

    // Async reset mid-stall
    lw(3'd6); tick();
    use1(3'd6, 1'b0);
    @(negedge clk);
    check("pre-rst stall_a", 32'(stall_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst stall_a", 32'(stall_a), 32'd0);
    check("async rst stall_b", 32'(stall_b), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post-rst busy_a",  32'(busy_a), 32'h00);
    check("post-rst busy_b",  32'(busy_b), 32'h00);
    check("post-rst count_a", 32'(sc_a),   32'd0);
    check("post-rst count_b", 32'(sc_b),   32'd0);
    tick(); idle(); tick();

    // Saturation: 7 rounds x 3 stalls on the LOAD_LAT=3 / PERF_W=4 build
    for (int i = 0; i < 7; i++) begin
      lw(3'd1); tick();
      use1(3'd1, 1'b0);
      repeat (4) tick();
    end
    idle();
    @(negedge clk);
    check("sat count_b", 32'(sc_b), 32'hF);
    check("sat count_a", 32'(sc_a), 32'd7);
    repeat (2) tick();

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
